decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 3-to-8 decoder between 8 requesters.
- Selects one requester, drives the decoder enable and 3-bit select, and also provides the matching one-hot grant vector.
- Holds the grant until the owner releases it, or until an optional hold timeout fires.
- Sits between the requester logic and decoder_3_8; its outputs connect directly to the decoder's En/I pins.

---
 rtl/decoder_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin arbiter that shares one 3-to-8 decoder
// between 8 requesters. All outputs are registered.
//
// Handshake: a requester holds req[k] high for as long as it wants the
// decoder. A grant is shown by En=1, I=k, Y=1<<k. The owner ends its grant by
// pulsing done or by dropping req[k]. Every grant is followed by one dead
// RELEASE cycle and one IDLE arbitration cycle before the next grant.
//
// Optional macro TIMEOUT_EN: compiles in an 8-bit hold counter. A grant is
// then forced to end after exactly HOLD_MAX cycles, and timeout pulses during
// the RELEASE cycle that follows.
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic       En,
  output logic [2:0] I,
  output logic [7:0] Y,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  // Elaboration-time check of the legal hold length
  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("HOLD_MAX must be in 1..255");
    end
  endgenerate

  state_e     state_q, state_d;
  logic       en_q, en_d;
  logic [2:0] i_q, i_d;
  logic [7:0] y_q, y_d;
  logic       busy_q, busy_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel;
  logic       found;
  logic       release_now;
`ifdef TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic       hold_hit;
`endif

  // Round-robin search: first set request after ptr, wrapping modulo 8
  always_comb begin
    sel   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] idx;
      idx = ptr_q + 3'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/GRANT/RELEASE FSM
  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    i_d         = i_q;
    y_d         = y_q;
    busy_d      = busy_q;
    ptr_d       = ptr_q;
    release_now = 1'b0;
`ifdef TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
    hold_hit    = (cnt_q == 8'(HOLD_MAX - 1));
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          en_d    = 1'b1;
          i_d     = sel;
          y_d     = 8'h01 << sel;
          busy_d  = 1'b1;
`ifdef TIMEOUT_EN
          cnt_d   = 8'h00;
`endif
        end
      end
      S_GRANT: begin
        release_now = done || !req[i_q];
`ifdef TIMEOUT_EN
        cnt_d = cnt_q + 8'h01;
        // A forced release is flagged only when nothing else ended the grant
        timeout_d   = hold_hit && !release_now;
        release_now = release_now || hold_hit;
`endif
        if (release_now) begin
          state_d = S_RELEASE;
          en_d    = 1'b0;
          y_d     = 8'h00;
          ptr_d   = i_q;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
        y_d     = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      i_q     <= 3'd0;
      y_q     <= 8'h00;
      busy_q  <= 1'b0;
      ptr_q   <= 3'd7;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      i_q     <= i_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef TIMEOUT_EN
  // Hold counter and timeout pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'h00;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign En   = en_q;
  assign I    = i_q;
  assign Y    = y_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Testbench for decoder_rr_arbiter: directed table, hand sequences for reset
// and hold behaviour, then random traffic against a transaction-level model.
module tb_decoder_rr_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic       En;
  logic [2:0] I;
  logic [7:0] Y;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  decoder_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .En(En), .I(I), .Y(Y), .busy(busy), .timeout(timeout)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // owner: granted requester or -1; dead: a post-grant gap cycle is pending;
  // last: most recently released owner (7 after reset); len: cycles held.
  int   m_owner, m_dead, m_last, m_i, m_len;
  logic m_to;
  logic timeout_on;

  function automatic void model_reset();
    m_owner = -1; m_dead = 0; m_last = 7; m_i = 0; m_len = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step(logic [7:0] r, logic d);
    logic hit, normal;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      m_len  = m_len + 1;
      hit    = timeout_on && (m_len == HOLD_MAX);
      normal = d || !r[m_owner];
      if (normal || hit) begin
        m_last  = m_owner;
        m_owner = -1;
        m_dead  = 1;
        m_to    = hit && !normal;
      end
    end else if (m_dead != 0) begin
      m_dead = 0;
    end else if (r != 8'h00) begin
      int  pick;
      bit  got;
      pick = 0; got = 0;
      for (int j = 1; j <= 8; j++) begin
        int c;
        c = (m_last + j) % 8;
        if (!got && r[c]) begin pick = c; got = 1; end
      end
      m_owner = pick; m_i = pick; m_len = 0;
    end
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compares all outputs against the model plus the structural invariants
  task automatic check_model(input string tag);
    logic       e_en;
    logic [7:0] e_y;
    e_en = (m_owner >= 0);
    e_y  = e_en ? (8'h01 << m_i) : 8'h00;
    exp_q.push_back({20'd0, e_en, 3'(m_i), e_y});
    chk({tag, ".en"}, {31'd0, En}, {31'd0, e_en});
    chk({tag, ".i"}, {29'd0, I}, 32'(m_i));
    chk({tag, ".y"}, {24'd0, Y}, {24'd0, e_y});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, (m_owner >= 0) || (m_dead != 0)});
    chk({tag, ".timeout"}, {31'd0, timeout}, {31'd0, m_to});
    chk({tag, ".onehot"}, {31'd0, $onehot0(Y)}, 32'd1);
    chk({tag, ".en_eq_or_y"}, {31'd0, En}, {31'd0, |Y});
    void'(exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive inputs, take one rising edge, sample at negedge
  task automatic cycle(input logic [7:0] r, input logic d, input string tag);
    req  = r;
    done = d;
    @(posedge clk);
    model_step(r, d);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    req = 8'h00; done = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.en", {31'd0, En}, 32'd0);
    chk("reset.i", {29'd0, I}, 32'd0);
    chk("reset.y", {24'd0, Y}, 32'd0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] i;
    logic [7:0] y;
    logic       busy;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl[NV];

  task automatic set_v(input int n, input logic [7:0] r, input logic d, input logic e,
                       input logic [2:0] i, input logic [7:0] y, input logic b);
    tbl[n].req = r; tbl[n].done = d; tbl[n].en = e;
    tbl[n].i = i; tbl[n].y = y; tbl[n].busy = b;
  endtask

  initial begin
`ifdef TIMEOUT_EN
    timeout_on = 1'b1;
`else
    timeout_on = 1'b0;
`endif
    rst_n = 1'b0; req = 8'h00; done = 1'b0;
    model_reset();

    // Single requester, release by done, then round-robin walk, withdraw, wrap
    set_v( 0, 8'h01, 0, 1, 3'd0, 8'h01, 1);
    set_v( 1, 8'h01, 1, 0, 3'd0, 8'h00, 1);
    set_v( 2, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    set_v( 3, 8'h00, 0, 0, 3'd0, 8'h00, 0);
    set_v( 4, 8'hFF, 0, 1, 3'd1, 8'h02, 1);
    set_v( 5, 8'hFF, 1, 0, 3'd1, 8'h00, 1);
    set_v( 6, 8'hFF, 0, 0, 3'd1, 8'h00, 0);
    set_v( 7, 8'hFF, 0, 1, 3'd2, 8'h04, 1);
    set_v( 8, 8'hFF, 1, 0, 3'd2, 8'h00, 1);
    set_v( 9, 8'hFF, 0, 0, 3'd2, 8'h00, 0);
    set_v(10, 8'hFF, 0, 1, 3'd3, 8'h08, 1);
    set_v(11, 8'hF7, 0, 0, 3'd3, 8'h00, 1);
    set_v(12, 8'hF7, 0, 0, 3'd3, 8'h00, 0);
    set_v(13, 8'hF7, 0, 1, 3'd4, 8'h10, 1);
    set_v(14, 8'h00, 0, 0, 3'd4, 8'h00, 1);
    set_v(15, 8'h00, 0, 0, 3'd4, 8'h00, 0);
    set_v(16, 8'h41, 0, 1, 3'd6, 8'h40, 1);
    set_v(17, 8'h41, 1, 0, 3'd6, 8'h00, 1);
    set_v(18, 8'h41, 0, 0, 3'd6, 8'h00, 0);
    set_v(19, 8'h41, 0, 1, 3'd0, 8'h01, 1);
    set_v(20, 8'h41, 1, 0, 3'd0, 8'h00, 1);
    set_v(21, 8'h41, 0, 0, 3'd0, 8'h00, 0);
    set_v(22, 8'h41, 0, 1, 3'd6, 8'h40, 1);
    set_v(23, 8'h00, 0, 0, 3'd6, 8'h00, 1);
    set_v(24, 8'h00, 0, 0, 3'd6, 8'h00, 0);

    @(negedge clk);
    do_reset();
    for (int n = 0; n < NV; n++) begin
      cycle(tbl[n].req, tbl[n].done, $sformatf("tbl%0d", n));
      chk($sformatf("tbl%0d.en", n), {31'd0, En}, {31'd0, tbl[n].en});
      chk($sformatf("tbl%0d.i", n), {29'd0, I}, {29'd0, tbl[n].i});
      chk($sformatf("tbl%0d.y", n), {24'd0, Y}, {24'd0, tbl[n].y});
      chk($sformatf("tbl%0d.busy", n), {31'd0, busy}, {31'd0, tbl[n].busy});
      chk($sformatf("tbl%0d.timeout", n), {31'd0, timeout}, 32'd0);
    end

    // Full walk with all requesting: order 0..7,0
    do_reset();
    for (int k = 0; k < 9; k++) begin
      cycle(8'hFF, 1'b0, "walk.grant");
      chk("walk.order", {29'd0, I}, 32'(k % 8));
      chk("walk.y", {24'd0, Y}, {24'd0, 8'h01 << (k % 8)});
      cycle(8'hFF, 1'b1, "walk.rel");
      cycle(8'hFF, 1'b0, "walk.idle");
    end

    // Asynchronous reset mid-grant, then priority restarts from requester 0
    do_reset();
    cycle(8'h20, 1'b0, "arst.grant");
    chk("arst.grant_i", {29'd0, I}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.en", {31'd0, En}, 32'd0);
    chk("arst.y", {24'd0, Y}, 32'd0);
    chk("arst.busy", {31'd0, busy}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(8'hA0, 1'b0, "arst.regrant");
    chk("arst.regrant_i", {29'd0, I}, 32'd5);
    cycle(8'hA0, 1'b1, "arst.rel");

    // Sole requester holding with no done
    do_reset();
    begin
      int pulses, en_cycles;
      pulses = 0; en_cycles = 0;
`ifdef TIMEOUT_EN
      cycle(8'h10, 1'b0, "hold.first");
      for (int t = 0; t < HOLD_MAX + 2; t++) begin
        if (En) en_cycles++;
        if (timeout) pulses++;
        cycle(8'h10, 1'b0, "hold");
      end
      chk("hold.en_cycles", 32'(en_cycles), 32'(HOLD_MAX));
      chk("hold.timeout_pulses", 32'(pulses), 32'd1);
      chk("hold.regrant_en", {31'd0, En}, 32'd1);
      chk("hold.regrant_i", {29'd0, I}, 32'd4);
`else
      cycle(8'h10, 1'b0, "hold.first");
      for (int t = 0; t < 20; t++) begin
        if (En) en_cycles++;
        if (timeout) pulses++;
        cycle(8'h10, 1'b0, "hold");
      end
      chk("hold.en_cycles", 32'(en_cycles), 32'd20);
      chk("hold.timeout_pulses", 32'(pulses), 32'd0);
`endif
    end

    // Random traffic against the model
    do_reset();
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) r = 8'h00;
        cycle(r, 1'($urandom_range(0, 4) == 0), "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
